// File: rtl/btn_request_ctrl.sv
// Button request conditioner for the traffic-light timing controller.
// Synchronises, debounces and edge-detects the pedestrian and emergency
// buttons, then holds each accepted request as a level until the
// controller acknowledges it. Adds pedestrian hold-off and a saturating
// count of accepted pedestrian requests.
module btn_request_ctrl #(
    parameter int DEB_CYCLES  = 4,
    parameter int PED_HOLDOFF = 8,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pedRaw,
    input  logic             emRaw,
    input  logic             pedAck,
    input  logic             emClear,
    output logic             pedBtn,
    output logic             emBtn,
    output logic             pedPending,
    output logic             holdoff,
    output logic [CNT_W-1:0] reqCount
);

    localparam int DW = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES + 1)  : 1;
    localparam int HW = (PED_HOLDOFF > 1) ? $clog2(PED_HOLDOFF + 1) : 1;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(PED_HOLDOFF);

    // Request counter never wraps: it sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic          ped_s1_q, ped_s2_q, em_s1_q, em_s2_q;
    logic          ped_lvl_q, ped_lvl_d, em_lvl_q, em_lvl_d;
    logic          ped_lvl_dly_q, em_lvl_dly_q;
    logic [DW-1:0] ped_cnt_q, ped_cnt_d, em_cnt_q, em_cnt_d;
    logic          pend_q, pend_d, em_req_q, em_req_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic          ped_rise, em_rise;

    // Debounce next-state: a level flips only after DEB_CYCLES consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        ped_lvl_d = ped_lvl_q;
        ped_cnt_d = '0;
        em_lvl_d  = em_lvl_q;
        em_cnt_d  = '0;
        if (ped_s2_q != ped_lvl_q) begin
            if (ped_cnt_q == DEB_LAST) ped_lvl_d = ~ped_lvl_q;
            else                       ped_cnt_d = ped_cnt_q + 1'b1;
        end
        if (em_s2_q != em_lvl_q) begin
            if (em_cnt_q == DEB_LAST) em_lvl_d = ~em_lvl_q;
            else                      em_cnt_d = em_cnt_q + 1'b1;
        end
    end

    assign ped_rise = ped_lvl_q & ~ped_lvl_dly_q;
    assign em_rise  = em_lvl_q  & ~em_lvl_dly_q;

    // Request latch next-state. pedAck beats a coincident press; an
    // emergency press beats a coincident clear.
    always_comb begin
        pend_d   = pend_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        em_req_d = em_req_q;
        if (pedAck) begin
            pend_d = 1'b0;
            hold_d = HOLD_LOAD;
        end else begin
            if (hold_q != '0) hold_d = hold_q - 1'b1;
            if (ped_rise && (hold_q == '0) && !pend_q) begin
                pend_d = 1'b1;
                cnt_d  = sat_inc(cnt_q);
            end
        end
        if (em_rise)                   em_req_d = 1'b1;
        else if (emClear && !em_lvl_q) em_req_d = 1'b0;
    end

    // Input synchronisers, debounce state and edge-detect delay registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ped_s1_q      <= 1'b0;
            ped_s2_q      <= 1'b0;
            em_s1_q       <= 1'b0;
            em_s2_q       <= 1'b0;
            ped_lvl_q     <= 1'b0;
            em_lvl_q      <= 1'b0;
            ped_cnt_q     <= '0;
            em_cnt_q      <= '0;
            ped_lvl_dly_q <= 1'b0;
            em_lvl_dly_q  <= 1'b0;
        end else begin
            ped_s1_q      <= pedRaw;
            ped_s2_q      <= ped_s1_q;
            em_s1_q       <= emRaw;
            em_s2_q       <= em_s1_q;
            ped_lvl_q     <= ped_lvl_d;
            em_lvl_q      <= em_lvl_d;
            ped_cnt_q     <= ped_cnt_d;
            em_cnt_q      <= em_cnt_d;
            ped_lvl_dly_q <= ped_lvl_q;
            em_lvl_dly_q  <= em_lvl_q;
        end
    end

    // Request latches, hold-off timer and request counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q   <= 1'b0;
            em_req_q <= 1'b0;
            hold_q   <= '0;
            cnt_q    <= '0;
        end else begin
            pend_q   <= pend_d;
            em_req_q <= em_req_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
        end
    end

    // Emergency masks the pedestrian request without discarding it.
    assign pedBtn     = pend_q & ~em_req_q;
    assign emBtn      = em_req_q;
    assign pedPending = pend_q;
    assign holdoff    = (hold_q != '0);
    assign reqCount   = cnt_q;

endmodule

// File: tb/tb_btn_request_ctrl.sv
// Scoreboard bench for btn_request_ctrl (DEB_CYCLES=4, PED_HOLDOFF=8, CNT_W=2).
// Expected output vectors {pedBtn, emBtn, pedPending, holdoff, reqCount}
// are queued with the clock-edge count at which they must hold; a monitor
// samples on the falling edge and checks each entry when its edge arrives.
module tb_btn_request_ctrl;

    logic       clk = 1'b0;
    logic       reset, pedRaw, emRaw, pedAck, emClear;
    logic       pedBtn, emBtn, pedPending, holdoff;
    logic [1:0] reqCount;

    btn_request_ctrl #(
        .DEB_CYCLES (4),
        .PED_HOLDOFF(8),
        .CNT_W      (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pedRaw    (pedRaw),
        .emRaw     (emRaw),
        .pedAck    (pedAck),
        .emClear   (emClear),
        .pedBtn    (pedBtn),
        .emBtn     (emBtn),
        .pedPending(pedPending),
        .holdoff   (holdoff),
        .reqCount  (reqCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [5:0] v;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [5:0] v, input string nm);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare every expectation that falls due at this edge count.
    always @(negedge clk) begin
        logic [5:0] act;
        exp_t       e;
        act = {pedBtn, emBtn, pedPending, holdoff, reqCount};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            tests++;
            if (e.cyc != cyc) begin
                fails++;
                $display("FAIL %s: check due at edge %0d reached at edge %0d", e.nm, e.cyc, cyc);
            end else if (act !== e.v) begin
                fails++;
                $display("FAIL %s @edge %0d: got %b required %b", e.nm, cyc, act, e.v);
            end
        end
    end

    initial begin
        reset = 1'b1; pedRaw = 1'b0; emRaw = 1'b0; pedAck = 1'b0; emClear = 1'b0;
        push(3, 6'b000000, "reset_state");

        // Bounce: two-cycle pulses never survive debounce
        at(4);   reset = 1'b0; pedRaw = 1'b1;
        at(6);   pedRaw = 1'b0;
        at(8);   pedRaw = 1'b1;
        at(10);  pedRaw = 1'b0;
        push(20, 6'b000000, "bounce_reject");

        // Clean press: request appears 7 edges after the drive (6 after first sample)
        at(20);  pedRaw = 1'b1;
        push(26, 6'b000000, "press_latency_pre");
        push(27, 6'b101001, "press_accept");
        push(40, 6'b101001, "press_held_stable");
        at(40);  pedRaw = 1'b0;

        // Ack and hold-off window of exactly 8 cycles
        at(50);  pedAck = 1'b1;
        push(50, 6'b101001, "pre_ack");
        push(51, 6'b000101, "ack_clears");
        push(58, 6'b000101, "holdoff_last");
        push(59, 6'b000001, "holdoff_end");
        at(51);  pedAck = 1'b0; pedRaw = 1'b1;
        push(62, 6'b000001, "holdoff_drop");
        at(60);  pedRaw = 1'b0;
        at(70);  pedRaw = 1'b1;
        push(76, 6'b000001, "press2_pre");
        push(77, 6'b101010, "press2_accept");

        // Emergency masks the pending pedestrian request
        at(80);  pedRaw = 1'b0; emRaw = 1'b1;
        push(86, 6'b101010, "em_pre");
        push(87, 6'b011010, "em_mask");
        at(90);  emClear = 1'b1;
        push(95, 6'b011010, "em_clear_held");
        at(95);  emRaw = 1'b0;
        push(101, 6'b011010, "em_release_pre");
        push(102, 6'b101010, "em_release_unmask");
        at(105); emClear = 1'b0;

        // pedAck coincident with a press rise: ack wins
        at(110); pedAck = 1'b1;
        push(111, 6'b000110, "ack_idle_holdoff");
        push(119, 6'b000010, "holdoff_end2");
        at(111); pedAck = 1'b0;
        at(120); pedRaw = 1'b1;
        push(126, 6'b000010, "coincide_pre");
        at(126); pedAck = 1'b1;
        push(127, 6'b000110, "ack_beats_rise");
        at(127); pedAck = 1'b0;
        at(130); pedRaw = 1'b0;
        push(135, 6'b000010, "holdoff_end3");

        // Emergency press while emClear already high still sets emBtn
        at(140); emClear = 1'b1; emRaw = 1'b1;
        push(146, 6'b000010, "em_clr_pre");
        push(147, 6'b010010, "em_rise_vs_clear");
        push(150, 6'b010010, "em_clr_held");
        at(150); emRaw = 1'b0;
        push(156, 6'b010010, "em_clr_release_pre");
        push(157, 6'b000010, "em_clr_release");

        // Saturation: third and fourth accepted requests with CNT_W=2
        at(160); emClear = 1'b0; pedRaw = 1'b1;
        push(166, 6'b000010, "req3_pre");
        push(167, 6'b101011, "req3_accept");
        at(170); pedAck = 1'b1; pedRaw = 1'b0;
        push(171, 6'b000111, "ack3");
        push(179, 6'b000011, "holdoff_end4");
        at(171); pedAck = 1'b0;
        at(180); pedRaw = 1'b1;
        push(186, 6'b000011, "req4_pre");
        push(187, 6'b101011, "req4_saturate");

        // Reset with both requests active clears everything
        at(190); emRaw = 1'b1;
        push(196, 6'b101011, "both_pre");
        push(197, 6'b011011, "both_active");
        at(200); reset = 1'b1; pedRaw = 1'b0; emRaw = 1'b0;
        push(201, 6'b000000, "reset_mid_request");
        at(202); reset = 1'b0;
        push(210, 6'b000000, "post_reset_idle");

        at(212);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
